// File: rtl/cs_pkg.sv
// Shared types and helpers for the cyclic-shift + XOR encoder/decoder pair.
package cs_pkg;

  localparam int unsigned L     = 11;
  localparam int unsigned DW    = L - 1;
  localparam int unsigned K_DEF = 5;
  localparam int unsigned M_DEF = 3;

  typedef logic [L-1:0] sym_lift_t;

  typedef enum logic {S_LOAD, S_EMIT} state_t;

  // Default masks: row0 = rot1(d0) ^ d1, row1 = d0 ^ rot2(d2); element [j][i]
  localparam logic [K_DEF-M_DEF-1:0][M_DEF-1:0][L-1:0] COEFF_DEF = {
    11'h004, 11'h000, 11'h001,
    11'h000, 11'h001, 11'h002
  };

  // Parity-lift a wire symbol so every lifted word has even weight
  function automatic sym_lift_t lift(logic [DW-1:0] d);
    return {^d, d};
  endfunction

  // Left rotation modulo L
  function automatic sym_lift_t rotl(sym_lift_t x, int unsigned s);
    int unsigned sh;
    sh = s % L;
    if (sh == 0) return x;
    return (x << sh) | (x >> (L - sh));
  endfunction

  // XOR of rotl(x, s) for every set bit s of the mask
  function automatic sym_lift_t apply_mask(sym_lift_t mask, sym_lift_t x);
    sym_lift_t r;
    r = '0;
    for (int unsigned s = 0; s < L; s++) begin
      if (mask[s]) r = r ^ rotl(x, s);
    end
    return r;
  endfunction

endpackage

// File: rtl/cs_mask_mul.sv
// Combinational mask x lifted-symbol product for one redundancy row.
module cs_mask_mul
  import cs_pkg::*;
(
  input  sym_lift_t mask_i,
  input  sym_lift_t sym_i,
  output sym_lift_t prod_c_o
);

  assign prod_c_o = apply_mask(mask_i, sym_i);

endmodule

// File: rtl/cs_encoder_stream.sv
// Streaming systematic cyclic-shift + XOR encoder: M data symbols in, K coded symbols out.
module cs_encoder_stream
  import cs_pkg::*;
#(
  parameter int unsigned K = K_DEF,
  parameter int unsigned M = M_DEF,
  parameter logic [K-M-1:0][M-1:0][L-1:0] COEFF = COEFF_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DW-1:0]        in_data_i,
  input  logic                 in_last_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DW-1:0]        out_data_o,
  output logic [$clog2(K)-1:0] out_idx_o,
  output logic                 out_last_o,
  output logic                 err_o
);

  localparam int unsigned R  = K - M;
  localparam int unsigned CW = $clog2(K);
  localparam int unsigned IW = (M > 1) ? $clog2(M) : 1;

  state_t                  state_q, state_d;
  logic [IW-1:0]           in_cnt_q, in_cnt_d;
  logic [CW-1:0]           out_cnt_q, out_cnt_d;
  logic [M-1:0][DW-1:0]    buf_q, buf_d;
  logic [R-1:0][L-1:0]     acc_q, acc_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic [DW-1:0]           out_data_q, out_data_d;
  logic [CW-1:0]           out_idx_q, out_idx_d;
  logic                    out_last_q, out_last_d;
  logic                    err_q, err_d;

  logic                    last_slot;
  sym_lift_t               lift_in;
  logic [R-1:0][L-1:0]     col_mask;
  logic [R-1:0][L-1:0]     prod;

  assign lift_in = lift(in_data_i);

  // COEFF column for the symbol slot currently being loaded
  always_comb begin
    col_mask = '0;
    for (int unsigned j = 0; j < R; j++) begin
      for (int unsigned i = 0; i < M; i++) begin
        if (in_cnt_q == IW'(i)) col_mask[j] = COEFF[j][i];
      end
    end
  end

  for (genvar j = 0; j < R; j++) begin : g_row
    cs_mask_mul u_mask_mul (
      .mask_i   (col_mask[j]),
      .sym_i    (lift_in),
      .prod_c_o (prod[j])
    );
  end

  // Next-state, counters, buffer/accumulator updates and registered output values
  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    buf_d     = buf_q;
    acc_d     = acc_q;
    err_d     = 1'b0;
    last_slot = (in_cnt_q == IW'(M - 1));

    case (state_q)
      S_LOAD: begin
        if (in_valid_i && in_ready_q) begin
          if (in_last_i != last_slot) begin
            // framing error: drop the partial block
            buf_d    = '0;
            acc_d    = '0;
            in_cnt_d = '0;
            err_d    = 1'b1;
          end else begin
            for (int unsigned i = 0; i < M; i++) begin
              if (in_cnt_q == IW'(i)) buf_d[i] = in_data_i;
            end
            for (int unsigned j = 0; j < R; j++) begin
              acc_d[j] = acc_q[j] ^ prod[j];
            end
            if (last_slot) begin
              in_cnt_d = '0;
              state_d  = S_EMIT;
            end else begin
              in_cnt_d = in_cnt_q + IW'(1);
            end
          end
        end
      end
      S_EMIT: begin
        if (out_ready_i) begin
          if (out_cnt_q == CW'(K - 1)) begin
            state_d   = S_LOAD;
            out_cnt_d = '0;
            acc_d     = '0;
          end else begin
            out_cnt_d = out_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase

    in_ready_d  = (state_d == S_LOAD);
    out_valid_d = (state_d == S_EMIT);
    out_idx_d   = (state_d == S_EMIT) ? out_cnt_d : '0;
    out_last_d  = (state_d == S_EMIT) && (out_cnt_d == CW'(K - 1));
    out_data_d  = '0;
    if (state_d == S_EMIT) begin
      for (int unsigned i = 0; i < M; i++) begin
        if (out_cnt_d == CW'(i)) out_data_d = buf_d[i];
      end
      for (int unsigned j = 0; j < R; j++) begin
        if (out_cnt_d == CW'(M + j)) out_data_d = acc_d[j][DW-1:0];
      end
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_LOAD;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      buf_q       <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      buf_q       <= buf_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_idx_o   = out_idx_q;
  assign out_last_o  = out_last_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_cs_encoder_stream.sv
// Self-checking bench for cs_encoder_stream with a block-level reference model and decoder.
module tb_cs_encoder_stream;

  localparam int K   = 5;
  localparam int M   = 3;
  localparam int L   = 11;
  localparam int DW  = 10;
  localparam int TMO = 200;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i = '0;
  logic          in_last_i = 1'b0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic [DW-1:0] out_data_o;
  logic [2:0]    out_idx_o;
  logic          out_last_o;
  logic          err_o;

  cs_encoder_stream dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_idx_o   (out_idx_o),
    .out_last_o  (out_last_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [DW-1:0] data;
    int            idx;
  } exp_t;

  exp_t                 exp_q[$];
  logic [2:0][DW-1:0]   blk_q[$];
  logic [DW-1:0]        part_q[$];
  logic [DW-1:0]        obs_q[$];
  logic [DW-1:0]        cur_out[K];
  logic                 err_exp = 1'b0;
  int                   err_cnt = 0;
  int                   checks = 0;
  int                   failures = 0;
  int                   rdy_mode = 0;
  logic                 prev_stall = 1'b0;
  logic [DW-1:0]        prev_data;
  logic [2:0]           prev_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [L-1:0] m_lift(input logic [DW-1:0] d);
    return {^d, d};
  endfunction

  // rotate left by s: bit b moves to bit (b+s) mod L
  function automatic logic [L-1:0] m_rot(input logic [L-1:0] x, input int s);
    logic [L-1:0] r;
    r = '0;
    for (int b = 0; b < L; b++) r[(b + s) % L] = x[b];
    return r;
  endfunction

  // Expected coded symbols of one well-formed block
  function automatic void push_block(input logic [2:0][DW-1:0] d);
    logic [L-1:0] r0, r1;
    r0 = m_rot(m_lift(d[0]), 1) ^ m_lift(d[1]);
    r1 = m_lift(d[0]) ^ m_rot(m_lift(d[2]), 2);
    exp_q.push_back('{data: d[0], idx: 0});
    exp_q.push_back('{data: d[1], idx: 1});
    exp_q.push_back('{data: d[2], idx: 2});
    exp_q.push_back('{data: r0[DW-1:0], idx: 3});
    exp_q.push_back('{data: r1[DW-1:0], idx: 4});
    blk_q.push_back(d);
  endfunction

  // Per-cycle compare against the model, then advance the model on handshakes
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      chk("rst_in_ready", 32'(in_ready_o), 32'd1);
      chk("rst_outs", 32'({out_valid_o, err_o, out_last_o, out_idx_o, out_data_o}), 32'd0);
      exp_q.delete();
      blk_q.delete();
      part_q.delete();
      err_exp = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("out_valid", 32'(out_valid_o), 32'(exp_q.size() != 0));
      chk("in_ready", 32'(in_ready_o), 32'(exp_q.size() == 0));
      chk("err", 32'(err_o), 32'(err_exp));
      if (err_o) err_cnt++;
      err_exp = 1'b0;
      if (out_valid_o && exp_q.size() != 0) begin
        chk("out_data", 32'(out_data_o), 32'(exp_q[0].data));
        chk("out_idx", 32'(out_idx_o), 32'(exp_q[0].idx));
        chk("out_last", 32'(out_last_o), 32'(exp_q[0].idx == K - 1));
      end
      if (prev_stall) begin
        chk("stall_data", 32'(out_data_o), 32'(prev_data));
        chk("stall_idx", 32'(out_idx_o), 32'(prev_idx));
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_data  = out_data_o;
      prev_idx   = out_idx_o;

      if (out_valid_o && out_ready_i && exp_q.size() != 0) begin
        obs_q.push_back(out_data_o);
        cur_out[exp_q[0].idx] = out_data_o;
        if (exp_q[0].idx == K - 1) begin
          logic [2:0][DW-1:0] d;
          logic [L-1:0] l0, l1, l2;
          d  = blk_q.pop_front();
          // decoder: rebuild dropped MSBs from even weight, then undo rotations
          l0 = m_lift(cur_out[0]);
          l1 = {^cur_out[3], cur_out[3]} ^ m_rot(l0, 1);
          l2 = m_rot({^cur_out[4], cur_out[4]} ^ l0, L - 2);
          chk("dec_d1", 32'(l1[DW-1:0]), 32'(d[1]));
          chk("dec_d2", 32'(l2[DW-1:0]), 32'(d[2]));
          chk("dec_d0", 32'(cur_out[0]), 32'(d[0]));
        end
        void'(exp_q.pop_front());
      end

      if (in_valid_i && in_ready_o) begin
        if (in_last_i && part_q.size() == M - 1) begin
          logic [2:0][DW-1:0] d;
          d = {in_data_i, part_q[1], part_q[0]};
          part_q.delete();
          push_block(d);
        end else if (in_last_i || part_q.size() == M - 1) begin
          err_exp = 1'b1;
          part_q.delete();
        end else begin
          part_q.push_back(in_data_i);
        end
      end
    end
  end

  // Downstream ready pattern: always, toggling, or random
  always @(posedge clk_i) begin
    #1;
    case (rdy_mode)
      0:       out_ready_i = 1'b1;
      1:       out_ready_i = ~out_ready_i;
      default: out_ready_i = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic send(input logic [DW-1:0] d, input logic last);
    int w;
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_last_i  = last;
    w = 0;
    @(negedge clk_i);
    while (!in_ready_o && w < TMO) begin
      w++;
      @(negedge clk_i);
    end
    if (w >= TMO) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready_o stuck low for %0d cycles", w);
    end
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    @(negedge clk_i);
    while ((exp_q.size() != 0 || !in_ready_o) && w < TMO) begin
      w++;
      @(negedge clk_i);
    end
    if (w >= TMO) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: block not drained, %0d symbols pending", exp_q.size());
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int e0;
    #1 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // hand-computed block: single bit in d0
    rdy_mode = 0;
    obs_q.delete();
    send(10'h001, 1'b0); send(10'h000, 1'b0); send(10'h000, 1'b1);
    wait_idle();
    chk("blk1_count", 32'(obs_q.size()), 32'd5);
    if (obs_q.size() == 5) begin
      chk("blk1_s0", 32'(obs_q[0]), 32'h001);
      chk("blk1_s2", 32'(obs_q[2]), 32'h000);
      chk("blk1_r0", 32'(obs_q[3]), 32'h003);
      chk("blk1_r1", 32'(obs_q[4]), 32'h001);
    end

    // rotation wraps: bit9 + parity rotated by 2
    obs_q.delete();
    send(10'h000, 1'b0); send(10'h000, 1'b0); send(10'h200, 1'b1);
    wait_idle();
    chk("blk2_count", 32'(obs_q.size()), 32'd5);
    if (obs_q.size() == 5) begin
      chk("blk2_r0", 32'(obs_q[3]), 32'h000);
      chk("blk2_r1", 32'(obs_q[4]), 32'h003);
    end

    // toggling backpressure
    rdy_mode = 1;
    obs_q.delete();
    send(10'h2A5, 1'b0); send(10'h13C, 1'b0); send(10'h3FF, 1'b1);
    wait_idle();
    chk("toggle_count", 32'(obs_q.size()), 32'd5);
    rdy_mode = 0;

    // early last: framing error then a clean block
    e0 = err_cnt;
    obs_q.delete();
    send(10'h055, 1'b0); send(10'h0AA, 1'b1);
    repeat (3) @(posedge clk_i);
    #1;
    chk("err_pulses", 32'(err_cnt - e0), 32'd1);
    chk("err_no_out", 32'(obs_q.size()), 32'd0);
    send(10'h101, 1'b0); send(10'h202, 1'b0); send(10'h304, 1'b1);
    wait_idle();
    chk("after_err_count", 32'(obs_q.size()), 32'd5);

    // reset mid-block
    send(10'h111, 1'b0); send(10'h222, 1'b0);
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    obs_q.delete();
    send(10'h001, 1'b0); send(10'h000, 1'b0); send(10'h000, 1'b1);
    wait_idle();
    chk("rst_blk_count", 32'(obs_q.size()), 32'd5);
    if (obs_q.size() == 5) chk("rst_blk_r0", 32'(obs_q[3]), 32'h003);

    // random blocks with random backpressure and occasional framing errors
    rdy_mode = 2;
    for (int b = 0; b < 1000; b++) begin
      if ($urandom_range(0, 19) == 0) begin
        int n;
        n = $urandom_range(1, 3);
        for (int s = 0; s < n; s++) send(10'($urandom), (s == n - 1) && (n < 3));
      end else begin
        for (int s = 0; s < M; s++) begin
          send(10'($urandom), s == M - 1);
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk_i);
          #1;
        end
      end
    end
    wait_idle();
    chk("drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
